dmem_bus_if: RTL and testbench
==============================

# dmem_bus_if

Data-side bus interface between the core's memory-access stage and the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). Accepts one load or store per request, stalls the pipeline while the transaction is outstanding, and formats data in both directions. Store data is right-justified into the bus lanes. Load data is sign- or zero-extended back to 32 bits. A watchdog aborts transactions that are never acknowledged.

## Interface
- TIMEOUT_CYCLES, 255: max BUSY cycles without ACKD_n before abort (1..255).
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage holds a load/store this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store source register value
- stall  out  1  hold upstream pipeline
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid with resp_valid
- bus_err  out  1  timeout abort, valid with resp_valid
- misalign  out  1  misaligned access, valid with resp_valid (see Configuration)
- DAD  out  32  bus address
- MREQ  out  1  bus request
- WRITE  out  1  bus write strobe
- SIZE  out  2  00 word, 01 half, 10 byte
- ACKD_n  in  1  active-low acknowledge
- DDT  inout  32  bus data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE + req_valid: latch addr, we, funct3 and wdata -> BUSY.
- BUSY: MREQ=1, DAD=latched addr, WRITE=latched we, SIZE from funct3[1:0] (00 byte -> 10, 01 half -> 01, 1x word -> 00).
  - ACKD_n==0 sampled: capture DDT for loads -> RESP.
  - Otherwise the wait counter increments. On reaching TIMEOUT_CYCLES -> RESP with bus_err=1 and rdata=0.
- RESP: resp_valid=1 for one cycle. Next state is BUSY if req_valid (back-to-back request latched), else IDLE.
- stall = (IDLE & req_valid) | BUSY | (RESP & req_valid); stall is low in the RESP cycle when no new request is present.
- Store lane formatting, DDT driven only in BUSY with WRITE=1, else high-Z:
  - SB: {24'b0, wdata[7:0]}
  - SH: {16'b0, wdata[15:0]}
  - SW: wdata
- Load extension of captured DDT:
  - LB: sign-extend [7:0]; LBU: zero-extend [7:0]
  - LH: sign-extend [15:0]; LHU: zero-extend [15:0]
  - LW and funct3 011/110/111: full word.
- funct3[2] is ignored for stores.
- Outputs held between events: rdata holds its value until the next RESP. DAD holds the last address.

## Timing
- Reset values: state IDLE, counter 0, MREQ 0, WRITE 0, SIZE 00, DAD 0, DDT high-Z, rdata 0, resp_valid 0, bus_err 0, misalign 0.
- Minimum latency: request seen at edge 0 -> MREQ high cycle 1 -> ACKD_n low sampled at edge 2 -> resp_valid in cycle 2.
- Each added wait cycle on ACKD_n adds one cycle.
- MREQ drops in the RESP cycle. Back-to-back requests produce one low MREQ cycle between transactions.
- rst asserted mid-BUSY: MREQ and WRITE drop and DDT releases immediately (asynchronously), with no resp_valid.
- ACKD_n low outside BUSY is ignored.

## Configuration
- DMEM_MISALIGN_CHK_EN defined:
  - Word access with addr[1:0]!=0, or half access with addr[0]!=0, skips BUSY (no MREQ) and goes IDLE -> RESP directly.
  - That RESP has misalign=1 and rdata=0.
- Undefined: address passed to the bus unmodified, and misalign is tied to 0.

## Structure
- Shared package dmem_pkg holds:
  - state enum (IDLE/BUSY/RESP)
  - SIZE codes
  - funct3 constants
  - TIMEOUT counter width (8)
- One combinational sub-module, dmem_load_ext: inputs funct3 and raw DDT, output the extended 32-bit result.

## Test plan
- LB at 0x80000003, bus returns 0x000000F0, ACKD_n in cycle 1 -> SIZE=10, rdata=0xFFFFFFF0, resp_valid in cycle 2.
- LHU at 0x80000002, bus returns 0x00008001, 3 wait cycles -> stall high 5 cycles, rdata=0x00008001.
- SB to 0xF0000000 with wdata=0x12345641 -> DDT=0x00000041, SIZE=10, WRITE=1 during BUSY; DDT high-Z after.
- ACKD_n never asserted with TIMEOUT_CYCLES=4 -> MREQ high 4 cycles, then resp_valid with bus_err=1, rdata=0.
- SW followed immediately by LW (req_valid held in RESP) -> MREQ low exactly one cycle between the two transactions; no request lost.
- LW at 0x80000002 with DMEM_MISALIGN_CHK_EN -> no MREQ, resp_valid cycle 1 with misalign=1. Without the macro -> normal bus access.
- rst pulsed during BUSY -> MREQ 0 within the same cycle, no resp_valid, next request proceeds normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus interface.
// Misaligned-access trapping is enabled by defining DMEM_MISALIGN_CHK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 8;

  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  // Stores are right-justified; funct3[2] has no meaning for stores.
  function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {24'b0, w[7:0]};
      2'b01:   return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1])      return a[1:0] != 2'b00;
    else if (f3[0]) return a[0];
    else            return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Sign/zero extension of raw bus data according to the load funct3.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext = {24'b0, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-side bus interface: one load/store per request, pipeline stall, watchdog abort.
// Define DMEM_MISALIGN_CHK_EN to trap misaligned half/word accesses without a bus cycle.
module dmem_bus_if
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        misalign,
  output logic [31:0] DAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n,
  inout  wire  [31:0] DDT,
  output dmem_state_e dbg_state
);

  // Handshake: a request is accepted when req_valid is high in IDLE or RESP;
  // the requester must hold it (stall high) until that cycle. resp_valid is a
  // single-cycle pulse with rdata/bus_err/misalign valid alongside it.

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      dad_q, dad_d;
  logic [1:0]       size_q, size_d;
  logic             mreq_q, mreq_d;
  logic             write_q, write_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_q, misalign_d;

  logic [31:0] load_data;
  logic        req_mis;
  logic        accept;

  dmem_load_ext u_load_ext (
    .funct3 (f3_q),
    .raw    (DDT),
    .ext    (load_data)
  );

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_mis = is_misaligned(req_funct3, req_addr);
`else
  assign req_mis = 1'b0;
`endif

  assign accept = req_valid && (state_q == IDLE || state_q == RESP);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    dad_d        = dad_q;
    size_d       = size_q;
    mreq_d       = 1'b0;
    write_d      = 1'b0;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    bus_err_d    = bus_err_q;
    misalign_d   = misalign_q;

    case (state_q)
      BUSY: begin
        if (!ACKD_n) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b0;
          misalign_d   = 1'b0;
          if (!we_q) rdata_d = load_data;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
          misalign_d   = 1'b0;
          rdata_d      = 32'b0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          mreq_d  = 1'b1;
          write_d = we_q;
        end
      end
      default: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = store_fmt(req_funct3, req_wdata);
          cnt_d   = '0;
          if (req_mis) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            misalign_d   = 1'b1;
            bus_err_d    = 1'b0;
            rdata_d      = 32'b0;
          end else begin
            state_d = BUSY;
            mreq_d  = 1'b1;
            write_d = req_we;
            dad_d   = req_addr;
            size_d  = size_of(req_funct3);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= 3'b0;
      wdata_q      <= 32'b0;
      dad_q        <= 32'b0;
      size_q       <= SIZE_WORD;
      mreq_q       <= 1'b0;
      write_q      <= 1'b0;
      rdata_q      <= 32'b0;
      resp_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      dad_q        <= dad_d;
      size_q       <= size_d;
      mreq_q       <= mreq_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      bus_err_q    <= bus_err_d;
      misalign_q   <= misalign_d;
    end
  end

  // write_q is only ever set in BUSY, so the bus is released as soon as reset hits.
  assign DDT = write_q ? wdata_q : {32{1'bz}};

  assign stall      = (state_q == BUSY) || (req_valid && (state_q == IDLE || state_q == RESP));
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign bus_err    = bus_err_q;
  assign misalign   = misalign_q;
  assign DAD        = dad_q;
  assign MREQ       = mreq_q;
  assign WRITE      = write_q;
  assign SIZE       = size_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if (watchdog set to 4 cycles).
module tb_dmem_bus_if;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, bus_err, misalign, mreq, write, ackd_n;
  logic [31:0] rdata, dad;
  logic [1:0]  size;
  dmem_state_e dbg_state;
  wire  [31:0] ddt;
  logic        tb_oe;
  logic [31:0] tb_dv;

  assign ddt = tb_oe ? tb_dv : {32{1'bz}};

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int          r_mreq, r_stall, r_cyc;
  logic        r_got, r_err, r_mis, r_write;
  logic [31:0] r_rd, r_dad, r_ddt;
  logic [1:0]  r_size;

  dmem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .bus_err(bus_err),
    .misalign(misalign), .DAD(dad), .MREQ(mreq), .WRITE(write), .SIZE(size),
    .ACKD_n(ackd_n), .DDT(ddt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE; waits < 0 means never acknowledge.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int waits, input logic [31:0] bus_data);
    r_mreq = 0; r_stall = 0; r_size = 2'b11; r_dad = 32'hdeadbeef; r_write = 1'b0; r_ddt = 32'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    if (stall) r_stall++;
    tick;
    req_valid = 1'b0;
    r_cyc = 1;
    while (!resp_valid && r_cyc < 300) begin
      if (stall) r_stall++;
      if (mreq) begin
        r_mreq++;
        if (r_mreq == 1) begin
          r_size = size; r_dad = dad; r_write = write; r_ddt = ddt;
        end
        if (!we) begin
          tb_oe = 1'b1; tb_dv = bus_data;
        end
        if (waits >= 0 && r_mreq > waits) ackd_n = 1'b0;
      end
      tick;
      r_cyc++;
      ackd_n = 1'b1; tb_oe = 1'b0;
    end
    if (stall) r_stall++;
    r_got = resp_valid; r_rd = rdata; r_err = bus_err; r_mis = misalign;
    tick;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; ackd_n = 1'b1; tb_oe = 1'b0; tb_dv = 32'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mreq", 32'(mreq), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_size", 32'(size), 32'd0);
    check("rst_dad", dad, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    rst = 1'b0;
    tick;

    // Acknowledge outside BUSY must be ignored.
    ackd_n = 1'b0;
    tick; tick;
    check("idle_ack_resp", 32'(resp_valid), 32'd0);
    check("idle_ack_mreq", 32'(mreq), 32'd0);
    ackd_n = 1'b1;
    tick;

    // LB, zero wait states
    exp_q.push_back(32'hFFFFFFF0);
    txn(1'b0, F3_B, 32'h80000003, 32'b0, 0, 32'h000000F0);
    check("lb_got", 32'(r_got), 32'd1);
    check("lb_lat", 32'(r_cyc), 32'd2);
    check("lb_size", 32'(r_size), 32'(SIZE_BYTE));
    check("lb_dad", r_dad, 32'h80000003);
    check("lb_write", 32'(r_write), 32'd0);
    check("lb_rdata", r_rd, exp_q.pop_front());
    check("lb_err", 32'(r_err), 32'd0);

    // LHU, three wait states
    exp_q.push_back(32'h00008001);
    txn(1'b0, F3_HU, 32'h80000002, 32'b0, 3, 32'h00008001);
    check("lhu_stall", 32'(r_stall), 32'd5);
    check("lhu_mreq", 32'(r_mreq), 32'd4);
    check("lhu_size", 32'(r_size), 32'(SIZE_HALF));
    check("lhu_rdata", r_rd, exp_q.pop_front());

    exp_q.push_back(32'hFFFF8001);
    txn(1'b0, F3_H, 32'h00000010, 32'b0, 1, 32'h00008001);
    check("lh_rdata", r_rd, exp_q.pop_front());

    exp_q.push_back(32'h000000F0);
    txn(1'b0, F3_BU, 32'h00000011, 32'b0, 0, 32'h0000A5F0);
    check("lbu_rdata", r_rd, exp_q.pop_front());

    // SB with release of DDT afterwards
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'hF0000000; req_wdata = 32'h12345641;
    tick;
    req_valid = 1'b0;
    check("sb_ddt", ddt, 32'h00000041);
    check("sb_size", 32'(size), 32'(SIZE_BYTE));
    check("sb_write", 32'(write), 32'd1);
    check("sb_dad", dad, 32'hF0000000);
    ackd_n = 1'b0;
    tick;
    ackd_n = 1'b1;
    check("sb_resp", 32'(resp_valid), 32'd1);
    check("sb_write_off", 32'(write), 32'd0);
    tb_oe = 1'b1; tb_dv = 32'h000000A0;
    #1;
    check("sb_ddt_release", ddt, 32'h000000A0);
    tb_oe = 1'b0;
    tick;

    // SH with funct3[2] set: still a halfword store
    txn(1'b1, 3'b101, 32'h00000020, 32'hCAFEBEEF, 0, 32'b0);
    check("sh_ddt", r_ddt, 32'h0000BEEF);
    check("sh_size", 32'(r_size), 32'(SIZE_HALF));
    check("sh_write", 32'(r_write), 32'd1);

    // Watchdog abort
    exp_q.push_back(32'h0);
    txn(1'b0, F3_W, 32'h00000100, 32'b0, -1, 32'b0);
    check("to_got", 32'(r_got), 32'd1);
    check("to_mreq", 32'(r_mreq), 32'd4);
    check("to_err", 32'(r_err), 32'd1);
    check("to_rdata", r_rd, exp_q.pop_front());

    exp_q.push_back(32'h11223344);
    txn(1'b0, F3_W, 32'h00000104, 32'b0, 2, 32'h11223344);
    check("after_to_err", 32'(r_err), 32'd0);
    check("after_to_rdata", r_rd, exp_q.pop_front());

    // SW then LW back-to-back
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h00000200; req_wdata = 32'h89ABCDEF;
    tick;
    req_valid = 1'b0;
    check("b2b_sw_mreq", 32'(mreq), 32'd1);
    check("b2b_sw_ddt", ddt, 32'h89ABCDEF);
    ackd_n = 1'b0;
    tick;
    ackd_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h00000204;
    #1;
    check("b2b_resp1", 32'(resp_valid), 32'd1);
    check("b2b_gap_mreq", 32'(mreq), 32'd0);
    check("b2b_gap_stall", 32'(stall), 32'd1);
    tick;
    req_valid = 1'b0;
    check("b2b_lw_mreq", 32'(mreq), 32'd1);
    check("b2b_lw_write", 32'(write), 32'd0);
    check("b2b_lw_dad", dad, 32'h00000204);
    tb_oe = 1'b1; tb_dv = 32'h0BADF00D; ackd_n = 1'b0;
    tick;
    tb_oe = 1'b0; ackd_n = 1'b1;
    check("b2b_resp2", 32'(resp_valid), 32'd1);
    check("b2b_rdata", rdata, 32'h0BADF00D);
    tick;

    // Reset asserted mid-BUSY on a store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h00000040; req_wdata = 32'h0000000F;
    tick;
    req_valid = 1'b0;
    check("rb_mreq_before", 32'(mreq), 32'd1);
    rst = 1'b1;
    #1;
    check("rb_mreq", 32'(mreq), 32'd0);
    check("rb_write", 32'(write), 32'd0);
    check("rb_stall", 32'(stall), 32'd0);
    tb_oe = 1'b1; tb_dv = 32'h000000A0;
    #1;
    check("rb_ddt_release", ddt, 32'h000000A0);
    tb_oe = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    check("rb_no_resp", 32'(resp_valid), 32'd0);
    exp_q.push_back(32'h00005A5A);
    txn(1'b0, F3_W, 32'h00000044, 32'b0, 0, 32'h00005A5A);
    check("rb_next_got", 32'(r_got), 32'd1);
    check("rb_next_rdata", r_rd, exp_q.pop_front());

    // Misaligned word load
`ifdef DMEM_MISALIGN_CHK_EN
    txn(1'b0, F3_W, 32'h80000002, 32'b0, 0, 32'h00000077);
    check("mis_mreq", 32'(r_mreq), 32'd0);
    check("mis_lat", 32'(r_cyc), 32'd1);
    check("mis_flag", 32'(r_mis), 32'd1);
    check("mis_rdata", r_rd, 32'd0);
`else
    txn(1'b0, F3_W, 32'h80000002, 32'b0, 0, 32'h00000077);
    check("mis_mreq", 32'(r_mreq), 32'd1);
    check("mis_lat", 32'(r_cyc), 32'd2);
    check("mis_flag", 32'(r_mis), 32'd0);
    check("mis_dad", r_dad, 32'h80000002);
    check("mis_rdata", r_rd, 32'h00000077);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
